// File: rtl/trng_collector.sv
// TRNG consumer end: divided-rate raw-bit sampling, von Neumann debiasing, byte
// packing into a show-ahead FIFO, and a repetition-count health monitor.
module trng_collector #(
  parameter int LEN        = 8,
  parameter int SAMPLE_DIV = 50,
  parameter int FIFO_DEPTH = 4,
  parameter int REP_LIMIT  = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic [LEN-1:0]              trnd_byte,
  output logic [7:0]                  rd_data,
  output logic                        rd_valid,
  input  logic                        rd_ready,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        overflow,
  output logic                        health_fail,
  input  logic                        health_clr
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = $clog2(SAMPLE_DIV);
  localparam int RW = $clog2(REP_LIMIT + 1);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [DW-1:0] DIV_LAST = DW'(SAMPLE_DIV - 1);
  localparam logic [RW-1:0] REP_MAX  = RW'(REP_LIMIT);

  typedef enum logic {VN_FIRST, VN_SECOND} vn_state_t;

  logic [DW-1:0]              div_cnt;
  logic                       strobe, raw;
  vn_state_t                  vn_q, vn_d;
  logic                       first_q, emit;
  logic [2:0]                 bit_cnt;
  logic [7:0]                 shreg, byte_val;
  logic                       byte_done;
  logic [RW-1:0]              rep_cnt, rep_nxt;
  logic                       prev_raw, rep_hit;
  logic [FIFO_DEPTH-1:0][7:0] mem;
  logic [AW-1:0]              wptr, rptr;
  logic                       full, pop, push, drop;

  assign strobe = enable && (div_cnt == DIV_LAST);
  assign raw    = ^trnd_byte;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                div_cnt <= '0;
    else if (!enable || strobe) div_cnt <= '0;
    else                       div_cnt <= div_cnt + 1'b1;
  end

  // Pairing FSM: second sample of a pair emits the first bit only if they differ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vn_q <= VN_FIRST;
    else        vn_q <= vn_d;
  end

  always_comb begin
    vn_d = vn_q;
    emit = 1'b0;
    if (!enable) vn_d = VN_FIRST;
    else if (strobe) begin
      unique case (vn_q)
        VN_FIRST:  vn_d = VN_SECOND;
        VN_SECOND: begin
          vn_d = VN_FIRST;
          emit = (first_q != raw);
        end
        default:   vn_d = VN_FIRST;
      endcase
    end
  end

  assign byte_val  = {shreg[6:0], first_q};
  assign byte_done = emit && (bit_cnt == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_q <= 1'b0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      if (strobe && vn_q == VN_FIRST) first_q <= raw;
      if (!enable)   bit_cnt <= '0;
      else if (emit) bit_cnt <= bit_cnt + 1'b1;
      if (emit) shreg <= byte_val;
    end
  end

  // Repetition monitor runs on every strobe, independent of debiasing.
  always_comb begin
    rep_nxt = RW'(1);
    if (raw == prev_raw) rep_nxt = (rep_cnt == REP_MAX) ? rep_cnt : rep_cnt + 1'b1;
  end
  assign rep_hit = strobe && (rep_nxt == REP_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt     <= '0;
      prev_raw    <= 1'b0;
      health_fail <= 1'b0;
    end else begin
      if (strobe) prev_raw <= raw;
      if (health_clr)  rep_cnt <= '0;
      else if (strobe) rep_cnt <= rep_nxt;
      if (rep_hit)         health_fail <= 1'b1;
      else if (health_clr) health_fail <= 1'b0;
    end
  end

  assign full     = (level == LVL_FULL);
  assign rd_valid = (level != '0);
  assign pop      = rd_valid && rd_ready;
  assign push     = byte_done && !health_fail && (!full || pop);
  assign drop     = byte_done && !health_fail && full && !pop;
  assign rd_data  = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem      <= '0;
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        mem[wptr] <= byte_val;
        wptr      <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      unique case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
      if (drop)            overflow <= 1'b1;
      else if (health_clr) overflow <= 1'b0;
    end
  end

endmodule
